// File: rtl/wave_param_ctrl_if.sv
// rtl/wave_param_ctrl_if.sv - push-button inputs and DDS tuning parameter outputs
interface wave_param_ctrl_if;
  logic        key_wave;
  logic        key_up;
  logic        key_down;
  logic        key_step;
  logic [1:0]  wave_sel;
  logic [19:0] wave_freq;
  logic [2:0]  step_sel;
  logic        param_update;

  modport master (
    output key_wave, key_up, key_down, key_step,
    input  wave_sel, wave_freq, step_sel, param_update
  );

  modport slave (
    input  key_wave, key_up, key_down, key_step,
    output wave_sel, wave_freq, step_sel, param_update
  );
endinterface

// File: rtl/wave_param_ctrl.sv
// rtl/wave_param_ctrl.sv - debounced button front end driving DDS wave type and frequency
module wave_param_ctrl #(
  parameter int unsigned DEBOUNCE_CYC      = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD_CYC = 5_000_000,
  parameter int unsigned FREQ_INIT         = 1_000,
  parameter int unsigned FREQ_MIN          = 1,
  parameter int unsigned FREQ_MAX          = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  wave_param_ctrl_if.slave  bus
);

  localparam int K_WAVE = 0;
  localparam int K_UP   = 1;
  localparam int K_DOWN = 2;
  localparam int K_STEP = 3;

  localparam int DEB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int REP_MAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ? REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [20:0] FMAX21 = 21'(FREQ_MAX);
  localparam logic [20:0] FMIN21 = 21'(FREQ_MIN);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  logic [3:0]       w_key_raw;
  logic [3:0]       r_sync1, r_sync2, r_deb, r_deb_d, r_press;
  logic [DEB_W-1:0] r_db_cnt [4];

  state_t           r_state, w_state_nxt;
  logic             r_dir_up, w_dir_up_nxt;
  logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic             w_rep, w_held_low, w_opp_low;

  logic [1:0]  r_wave, w_wave_nxt;
  logic [2:0]  r_step, w_step_nxt;
  logic [19:0] r_freq, w_freq_nxt;
  logic        r_upd;
  logic [20:0] w_step_val, w_sum, w_floor;
  logic        w_up_any, w_dn_any;

  assign w_key_raw = {bus.key_step, bus.key_down, bus.key_up, bus.key_wave};

  // Press pulse is registered one cycle after the debounced fall so events come off flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_deb   <= '1;
      r_deb_d <= '1;
      r_press <= '0;
      for (int k = 0; k < 4; k++) r_db_cnt[k] <= '0;
    end else begin
      r_sync1 <= w_key_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_press <= r_deb_d & ~r_deb;
      for (int k = 0; k < 4; k++) begin
        if (r_sync2[k] == r_deb[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DEB_W'(DEBOUNCE_CYC - 1)) begin
          r_deb[k]    <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign w_held_low = r_dir_up ? ~r_deb[K_UP]   : ~r_deb[K_DOWN];
  assign w_opp_low  = r_dir_up ? ~r_deb[K_DOWN] : ~r_deb[K_UP];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dir_up  <= 1'b0;
      r_rep_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dir_up  <= w_dir_up_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dir_up_nxt  = r_dir_up;
    w_rep_cnt_nxt = r_rep_cnt;
    w_rep         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rep_cnt_nxt = '0;
        if (r_press[K_UP] && !r_deb[K_UP] && r_deb[K_DOWN]) begin
          w_state_nxt  = S_DELAY;
          w_dir_up_nxt = 1'b1;
        end else if (r_press[K_DOWN] && !r_deb[K_DOWN] && r_deb[K_UP]) begin
          w_state_nxt  = S_DELAY;
          w_dir_up_nxt = 1'b0;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (!w_held_low || w_opp_low) begin
          w_state_nxt   = S_IDLE;
          w_rep_cnt_nxt = '0;
        end else if ((r_state == S_DELAY  && r_rep_cnt == REP_W'(REPEAT_DELAY_CYC - 1)) ||
                     (r_state == S_REPEAT && r_rep_cnt == REP_W'(REPEAT_PERIOD_CYC - 1))) begin
          w_rep         = 1'b1;
          w_rep_cnt_nxt = '0;
          w_state_nxt   = S_REPEAT;
        end else begin
          w_rep_cnt_nxt = r_rep_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_step)
      3'd0:    w_step_val = 21'd1;
      3'd1:    w_step_val = 21'd10;
      3'd2:    w_step_val = 21'd100;
      3'd3:    w_step_val = 21'd1_000;
      3'd4:    w_step_val = 21'd10_000;
      3'd5:    w_step_val = 21'd100_000;
      default: w_step_val = 21'd1;
    endcase
  end

  assign w_up_any = r_press[K_UP]   | (w_rep &  r_dir_up);
  assign w_dn_any = r_press[K_DOWN] | (w_rep & ~r_dir_up);
  assign w_sum    = {1'b0, r_freq} + w_step_val;
  assign w_floor  = w_step_val + FMIN21;

  // Frequency uses the pre-update step; simultaneous up and down cancel.
  always_comb begin
    w_freq_nxt = r_freq;
    if (w_up_any && !w_dn_any) begin
      w_freq_nxt = (w_sum > FMAX21) ? FMAX21[19:0] : w_sum[19:0];
    end else if (w_dn_any && !w_up_any) begin
      w_freq_nxt = ({1'b0, r_freq} < w_floor) ? FMIN21[19:0] : (r_freq - w_step_val[19:0]);
    end
  end

  always_comb begin
    w_wave_nxt = r_wave + {1'b0, r_press[K_WAVE]};
    w_step_nxt = r_step;
    if (r_press[K_STEP]) w_step_nxt = (r_step == 3'd5) ? 3'd0 : (r_step + 3'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wave <= '0;
      r_step <= 3'd3;
      r_freq <= 20'(FREQ_INIT);
      r_upd  <= 1'b0;
    end else begin
      r_wave <= w_wave_nxt;
      r_step <= w_step_nxt;
      r_freq <= w_freq_nxt;
      r_upd  <= (w_wave_nxt != r_wave) || (w_step_nxt != r_step) || (w_freq_nxt != r_freq);
    end
  end

  assign bus.wave_sel     = r_wave;
  assign bus.wave_freq    = r_freq;
  assign bus.step_sel     = r_step;
  assign bus.param_update = r_upd;

endmodule

// File: tb/tb_wave_param_ctrl.sv
// tb/tb_wave_param_ctrl.sv - directed vector bench for wave_param_ctrl
module tb_wave_param_ctrl;

  localparam int K_WAVE = 0;
  localparam int K_UP   = 1;
  localparam int K_DOWN = 2;
  localparam int K_STEP = 3;

  typedef struct {
    int key;
    int e_wave;
    int e_freq;
    int e_step;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  int   p0;
  vec_t vecs [19];

  wave_param_ctrl_if ifc();

  wave_param_ctrl #(
    .DEBOUNCE_CYC(8), .REPEAT_DELAY_CYC(40), .REPEAT_PERIOD_CYC(10),
    .FREQ_INIT(1000), .FREQ_MIN(1), .FREQ_MAX(1_000_000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ifc.param_update) pulses++;

  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      K_WAVE:  ifc.key_wave = v;
      K_UP:    ifc.key_up   = v;
      K_DOWN:  ifc.key_down = v;
      default: ifc.key_step = v;
    endcase
  endtask

  task automatic press_key(input int k);
    set_key(k, 1'b0);
    step_n(12);
    set_key(k, 1'b1);
    step_n(14);
  endtask

  task automatic press_n(input int k, input int n);
    for (int i = 0; i < n; i++) press_key(k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step_n(3);
    rst_n = 1'b1;
    step_n(2);
  endtask

  initial begin
    vecs[0]  = '{K_WAVE, 1, 2000, 3};
    vecs[1]  = '{K_WAVE, 2, 2000, 3};
    vecs[2]  = '{K_WAVE, 3, 2000, 3};
    vecs[3]  = '{K_WAVE, 0, 2000, 3};
    vecs[4]  = '{K_WAVE, 1, 2000, 3};
    vecs[5]  = '{K_STEP, 1, 2000, 4};
    vecs[6]  = '{K_STEP, 1, 2000, 5};
    vecs[7]  = '{K_STEP, 1, 2000, 0};
    vecs[8]  = '{K_STEP, 1, 2000, 1};
    vecs[9]  = '{K_STEP, 1, 2000, 2};
    vecs[10] = '{K_STEP, 1, 2000, 3};
    vecs[11] = '{K_UP,   1, 3000, 3};
    vecs[12] = '{K_DOWN, 1, 2000, 3};
    vecs[13] = '{K_STEP, 1, 2000, 4};
    vecs[14] = '{K_UP,   1, 12000, 4};
    vecs[15] = '{K_DOWN, 1, 2000, 4};
    vecs[16] = '{K_DOWN, 1, 1, 4};
    vecs[17] = '{K_STEP, 1, 1, 5};
    vecs[18] = '{K_UP,   1, 100001, 5};

    ifc.key_wave = 1'b1;
    ifc.key_up   = 1'b1;
    ifc.key_down = 1'b1;
    ifc.key_step = 1'b1;
    step_n(3);
    rst_n = 1'b1;
    step_n(2);
    chk("reset_wave", int'(ifc.wave_sel), 0);
    chk("reset_freq", int'(ifc.wave_freq), 1000);
    chk("reset_step", int'(ifc.step_sel), 3);
    chk("reset_upd", int'(ifc.param_update), 0);

    ifc.key_up = 1'b0;
    step_n(11);
    chk("up_latency_before", int'(ifc.wave_freq), 1000);
    step_n(1);
    chk("up_latency_at", int'(ifc.wave_freq), 2000);
    chk("up_pulse_high", int'(ifc.param_update), 1);
    step_n(1);
    chk("up_pulse_low", int'(ifc.param_update), 0);
    ifc.key_up = 1'b1;
    step_n(14);

    for (int i = 0; i < 19; i++) begin
      p0 = pulses;
      press_key(vecs[i].key);
      chk($sformatf("vec%0d_wave", i), int'(ifc.wave_sel), vecs[i].e_wave);
      chk($sformatf("vec%0d_freq", i), int'(ifc.wave_freq), vecs[i].e_freq);
      chk($sformatf("vec%0d_step", i), int'(ifc.step_sel), vecs[i].e_step);
      chk($sformatf("vec%0d_pulses", i), pulses - p0, 1);
    end

    do_reset();
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      ifc.key_down = 1'b0;
      step_n(5);
      ifc.key_down = 1'b1;
      step_n(3);
    end
    ifc.key_down = 1'b0;
    step_n(25);
    ifc.key_down = 1'b1;
    step_n(14);
    chk("bounce_freq", int'(ifc.wave_freq), 1);
    chk("bounce_pulses", pulses - p0, 1);

    do_reset();
    press_n(K_STEP, 2);
    press_n(K_UP, 9);
    press_n(K_STEP, 5);
    press_n(K_UP, 9);
    press_n(K_STEP, 5);
    press_n(K_UP, 8);
    press_n(K_STEP, 5);
    press_n(K_UP, 9);
    press_n(K_STEP, 5);
    press_n(K_UP, 5);
    chk("sat_pre_freq", int'(ifc.wave_freq), 999_950);
    press_n(K_STEP, 2);
    chk("sat_pre_step", int'(ifc.step_sel), 3);
    p0 = pulses;
    press_key(K_UP);
    chk("sat_clamp_freq", int'(ifc.wave_freq), 1_000_000);
    chk("sat_clamp_pulse", pulses - p0, 1);
    p0 = pulses;
    press_key(K_UP);
    chk("sat_hold_freq", int'(ifc.wave_freq), 1_000_000);
    chk("sat_hold_pulse", pulses - p0, 0);

    do_reset();
    press_n(K_STEP, 3);
    chk("rep_step", int'(ifc.step_sel), 0);
    p0 = pulses;
    ifc.key_up = 1'b0;
    step_n(12);
    chk("rep_press", int'(ifc.wave_freq), 1001);
    step_n(39);
    chk("rep_before_first", int'(ifc.wave_freq), 1001);
    step_n(1);
    chk("rep_first", int'(ifc.wave_freq), 1002);
    step_n(25);
    ifc.key_up = 1'b1;
    step_n(50);
    chk("rep_final_freq", int'(ifc.wave_freq), 1005);
    chk("rep_pulses", pulses - p0, 5);

    p0 = pulses;
    ifc.key_up   = 1'b0;
    ifc.key_down = 1'b0;
    step_n(70);
    ifc.key_up   = 1'b1;
    ifc.key_down = 1'b1;
    step_n(14);
    chk("simul_freq", int'(ifc.wave_freq), 1005);
    chk("simul_pulses", pulses - p0, 0);

    ifc.key_up = 1'b0;
    step_n(12);
    chk("mid_press", int'(ifc.wave_freq), 1006);
    step_n(18);
    rst_n = 1'b0;
    step_n(1);
    chk("mid_rst_wave", int'(ifc.wave_sel), 0);
    chk("mid_rst_freq", int'(ifc.wave_freq), 1000);
    chk("mid_rst_step", int'(ifc.step_sel), 3);
    chk("mid_rst_upd", int'(ifc.param_update), 0);
    step_n(1);
    rst_n = 1'b1;
    step_n(11);
    chk("held_rst_before", int'(ifc.wave_freq), 1000);
    step_n(1);
    chk("held_rst_press", int'(ifc.wave_freq), 2000);
    ifc.key_up = 1'b1;
    step_n(20);
    chk("held_rst_after", int'(ifc.wave_freq), 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
